multiword_add_ctrl: RTL and testbench
=====================================

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning width in bits of one adder slice.
REQ-002 The block SHALL have parameter NW, default 4, meaning number of W-bit words per operand (NW >= 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin an addition; accepted only in IDLE.
REQ-006 The block SHALL have port a, input, W*NW, first operand, captured on accept.
REQ-007 The block SHALL have port b, input, W*NW, second operand, captured on accept.
REQ-008 The block SHALL have port c_in, input, 1, carry into word 0, captured on accept.
REQ-009 The block SHALL have port abort, input, 1, cancel an operation in progress.
REQ-010 The block SHALL have port busy, output, 1, high in RUN.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-012 The block SHALL have port sum, output, W*NW, result; held stable from done until next accept.
REQ-013 The block SHALL have port c_out, output, 1, carry out of word NW-1; held like sum.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE.
REQ-015 IDLE with start=1 SHALL capture a, b, c_in into internal registers, clear word index to 0, and go to RUN.
REQ-016 In RUN, each cycle SHALL add word[idx] of a and b plus carry register using one W-bit slice, write the W-bit result to sum word idx, and load the slice carry into the carry register.
REQ-017 Word 0 SHALL use captured c_in as carry; word k>0 SHALL use carry out of word k-1.
REQ-018 After word NW-1 is written, the FSM SHALL go to DONE, with c_out = final carry; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-019 Latency SHALL be NW+1 cycles from accepting edge to done high; throughput one operation per NW+2 cycles.
REQ-020 start while in RUN or DONE SHALL be ignored (not queued).
REQ-021 abort in RUN SHALL return to IDLE next edge without pulsing done; sum/c_out contents are then undefined-but-stable and SHALL NOT be trusted.
REQ-022 abort and start together in IDLE: start SHALL win; abort in IDLE/DONE SHALL have no effect.
REQ-023 Result SHALL equal (a + b + c_in) mod 2^(W*NW+1), split as {c_out, sum}; all-ones + 0 + 1 SHALL wrap to sum=0, c_out=1.
REQ-024 The word index SHALL be ceil(log2(NW)) bits and SHALL never exceed NW-1.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, sum=0, c_out=0, carry register=0, index=0.
REQ-026 Reset asserted mid-RUN SHALL discard the operation; no done pulse SHALL follow deassertion.
REQ-027 Deassertion SHALL be synchronous-safe: first accept possible on the first rising edge after rst_n high.

Configuration
REQ-028 Macro MWADD_OVF_EN defined SHALL add output port ovf, 1 bit, = signed two's-complement overflow of the full-width add (carry into MSB XOR carry out), registered with c_out, reset 0.
REQ-029 Without MWADD_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default W/NW constants.
REQ-031 The W-bit add SHALL be one sub-module, adder_slice (ports c_out, sum, a, b, c_in, parameter W), purely combinational, instantiated once.

Verification
REQ-032 W=16,NW=4: a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0002, c_in=0 -> done after 5 cycles, sum=0x...0003, c_out=0.
REQ-033 a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> carry ripples through all words, sum=0, c_out=1 (ovf=0 with MWADD_OVF_EN).
REQ-034 a=0x7FFF_FFFF_FFFF_FFFF, b=1, c_in=0 with MWADD_OVF_EN -> sum=0x8000_0000_0000_0000, c_out=0, ovf=1.
REQ-035 start pulsed again 2 cycles after accept -> ignored; single done, result from first operands only.
REQ-036 abort at cycle 2 of RUN -> busy low next cycle, no done; following start with a=5,b=7 -> sum=12.
REQ-037 rst_n dropped mid-RUN -> outputs zero immediately; no done after release; random 1000-op compare against reference full-width sum.

Source files
------------

// File: rtl/multiword_add_ctrl_pkg.sv
// Shared definitions for the multi-word serial adder: FSM state encoding and
// the default slice width / word count.
package multiword_add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int W_DEF  = 16;
   localparam int NW_DEF = 4;

endpackage

// File: rtl/multiword_add_ctrl_adder_slice.sv
// Purely combinational W-bit adder slice with carry in and carry out.
module adder_slice #(
   parameter int W = 16
) (
   output logic         c_out,
   output logic [W-1:0] sum,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in
);

   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

endmodule

// File: rtl/multiword_add_ctrl.sv
// Serial multi-word adder: one W-bit slice reused over NW words, least significant first.
// Optional macro MWADD_OVF_EN adds a registered signed-overflow output ovf.
module multiword_add_ctrl
   import multiword_add_ctrl_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int NW = NW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [W*NW-1:0] a,
   input  logic [W*NW-1:0] b,
   input  logic            c_in,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic [W*NW-1:0] sum,
   output logic            c_out
`ifdef MWADD_OVF_EN
   ,
   output logic            ovf
`endif
);

   localparam int            IW       = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

   state_t          state, state_nxt;
   logic [IW-1:0]   idx;
   logic            carry_r;
   logic [W*NW-1:0] a_r, b_r;
   logic [W-1:0]    a_w, b_w, s_w;
   logic            c_w;
   logic            accept, step, last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            // start beats a simultaneous abort; abort alone is meaningless here
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (last) state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign last = (idx == LAST_IDX);
   assign a_w  = a_r[idx*W +: W];
   assign b_w  = b_r[idx*W +: W];

   adder_slice #(.W(W)) u_slice (
      .c_out (c_w),
      .sum   (s_w),
      .a     (a_w),
      .b     (b_w),
      .c_in  (carry_r)
   );

   // Operand copies are pure data and need no reset; they are only read in RUN.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_r <= a;
         b_r <= b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         carry_r <= 1'b0;
         sum     <= '0;
         c_out   <= 1'b0;
`ifdef MWADD_OVF_EN
         ovf     <= 1'b0;
`endif
      end else if (accept) begin
         idx     <= '0;
         carry_r <= c_in;
      end else if (step) begin
         sum[idx*W +: W] <= s_w;
         carry_r         <= c_w;
         if (!last) begin
            idx <= idx + 1'b1;
         end else begin
            c_out <= c_w;
`ifdef MWADD_OVF_EN
            // carry into the MSB is recovered from the top bits of the last slice
            ovf   <= c_w ^ (a_w[W-1] ^ b_w[W-1] ^ s_w[W-1]);
`endif
         end
      end
   end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl: directed corner cases plus random
// operations compared against a full-width arithmetic reference.
module tb_multiword_add_ctrl;

   localparam int W  = 16;
   localparam int NW = 4;
   localparam int TW = W * NW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [TW-1:0] a, b;
   logic          c_in;
   logic          abort;
   logic          busy, done;
   logic [TW-1:0] sum;
   logic          c_out;
`ifdef MWADD_OVF_EN
   logic          ovf;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   multiword_add_ctrl #(.W(W), .NW(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
`ifdef MWADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TW:0] ref_add(input logic [TW-1:0] av, input logic [TW-1:0] bv,
                                           input logic ci);
      return {1'b0, av} + {1'b0, bv} + {{TW{1'b0}}, ci};
   endfunction

   function automatic logic ref_ovf(input logic [TW-1:0] av, input logic [TW-1:0] bv,
                                    input logic ci);
      logic signed [TW+1:0] s, smax, smin;
      s    = $signed({{2{av[TW-1]}}, av}) + $signed({{2{bv[TW-1]}}, bv})
           + $signed({{(TW+1){1'b0}}, ci});
      smax = $signed({3'b000, {(TW-1){1'b1}}});
      smin = -smax - 1;
      return (s > smax) || (s < smin);
   endfunction

   // Issue one operation, wait (bounded) for done, check latency, result and pulse width.
   task automatic run_op(input logic [TW-1:0] av, input logic [TW-1:0] bv, input logic ci,
                         input logic ab, input string tag);
      logic [TW:0] exp;
      int          lat;
      bit          seen;
      exp = ref_add(av, bv, ci);
      @(negedge clk);
      a = av; b = bv; c_in = ci; start = 1'b1; abort = ab;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check({tag, "_busy"}, busy, 1);
      lat  = 1;
      seen = 0;
      while (!seen && lat <= NW + 4) begin
         if (done) seen = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_latency"}, lat, NW + 1);
      check({tag, "_sum"}, sum, exp[TW-1:0]);
      check({tag, "_cout"}, c_out, exp[TW]);
`ifdef MWADD_OVF_EN
      check({tag, "_ovf"}, ovf, ref_ovf(av, bv, ci));
`endif
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_sum_hold"}, sum, exp[TW-1:0]);
   endtask

   initial begin
      int          ndone;
      logic [TW:0] exp;
      logic [TW-1:0] ra, rb, got;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; c_in = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", c_out, 0);
`ifdef MWADD_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      rst_n = 1'b1;

      run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 1'b0, "small");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, "ripple");
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, "sovf");
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, "negovf");
      run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b1, "start_abort");

      // A second start during RUN must be ignored.
      exp = ref_add(64'h1234, 64'h1111, 1'b0);
      @(negedge clk);
      a = 64'h1234; b = 64'h1111; c_in = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      a = 64'hDEAD_BEEF_0000_0000; b = 64'h0BAD_F00D_0000_0000; c_in = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      ndone = 0; got = '0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin ndone++; got = sum; end
         @(negedge clk);
      end
      check("restart_ndone", ndone, 1);
      check("restart_sum", got, exp[TW-1:0]);

      // Abort in the second RUN cycle.
      @(negedge clk);
      a = 64'hFFFF; b = 64'h1; c_in = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_busy", busy, 0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_ndone", ndone, 0);
      run_op(64'd5, 64'd7, 1'b0, 1'b0, "post_abort");

      // Asynchronous reset mid-RUN.
      @(negedge clk);
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; c_in = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_sum", sum, 0);
      check("arst_cout", c_out, 0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("arst_ndone", ndone, 0);
      run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, "post_rst");

      // Random operations, with occasional carry-chain stress operands.
      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) begin
            ra = '1;
            rb = 64'(1) << $urandom_range(0, 63);
         end
         run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
